// File: rtl/dynamic_range_compressor.sv
// dynamic_range_compressor: per-channel feed-forward compressor.
// Processes one sample per 5 cycles through IDLE -> DETECT -> COMPUTE -> MULTIPLY -> OUTPUT.
// Build option: define COMPRESSOR_RELEASE_EN to make each channel's envelope release by
// one step per processed sample; without it the envelope equals the instantaneous gain reduction.
// Handshake: start is a request sampled only while busy=0 (and only for a valid channel);
// done is a one-cycle pulse marking output_sample/output_gain valid, both held until the next done.
module dynamic_range_compressor #(
    parameter int  WIDTH    = 12,
    parameter int  CHANNELS = 2,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    channel,
    input  logic [1:0]       compression_amount,
    input  logic [7:0]       threshold,
    input  logic [WIDTH-1:0] input_sample,
    output logic [WIDTH-1:0] output_sample,
    output logic [7:0]       output_gain,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DETECT   = 3'd1;
    localparam logic [2:0] COMPUTE  = 3'd2;
    localparam logic [2:0] MULTIPLY = 3'd3;
    localparam logic [2:0] OUTPUT   = 3'd4;

    localparam logic [CW:0]      CH_LIMIT = (CW + 1)'(CHANNELS);
    localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] MAG_MAX  = {1'b0, {(WIDTH - 1){1'b1}}};

    logic [2:0]             state;
    logic [CW-1:0]          chan_q;
    logic [1:0]             amt_q;
    logic [7:0]             thr_q;
    logic [WIDTH-1:0]       x_q;
    logic [7:0]             lvl_q;
    logic [7:0]             env_q;
    logic signed [WIDTH+9:0] prod_q;
    logic [7:0]             env [2**CW];

    logic [WIDTH-1:0]       mag;
    logic [4:0]             lead;
    logic [2:0]             frac;
    logic [7:0]             level;
    logic [7:0]             over;
    logic [7:0]             gr;
    logic [7:0]             env_next;
    logic [8:0]             gain_lin;
    logic signed [WIDTH+9:0] prod;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Level detector: saturated magnitude -> log2 level in 1/8 octave (leading-one index + 3 mantissa bits).
    always_comb begin
        if (x_q[WIDTH-1]) begin
            mag = (x_q == NEG_MIN) ? MAG_MAX : (~x_q + 1'b1);
        end else begin
            mag = x_q;
        end
        lead = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) lead = i[4:0];
        end
        frac  = 3'({mag, 3'b000} >> lead);
        level = (mag == '0) ? 8'd0 : {lead, frac};
    end

    // Gain computer: overshoot above threshold reduced by the selected ratio, then envelope update.
    always_comb begin
        over = (lvl_q > thr_q) ? (lvl_q - thr_q) : 8'd0;
        gr   = over - (over >> amt_q);
`ifdef COMPRESSOR_RELEASE_EN
        env_next = (gr >= env[chan_q]) ? gr : (env[chan_q] - 8'd1);
`else
        env_next = gr;
`endif
    end

    // Gain multiplier: fractional part of the envelope picks a 2^(-k/8) factor in Q8.
    always_comb begin
        case (env_q[2:0])
            3'd0:    gain_lin = 9'd256;
            3'd1:    gain_lin = 9'd235;
            3'd2:    gain_lin = 9'd215;
            3'd3:    gain_lin = 9'd197;
            3'd4:    gain_lin = 9'd181;
            3'd5:    gain_lin = 9'd166;
            3'd6:    gain_lin = 9'd152;
            default: gain_lin = 9'd139;
        endcase
        prod = $signed({{10{x_q[WIDTH-1]}}, x_q}) * $signed({{(WIDTH + 1){1'b0}}, gain_lin});
    end

    // Control FSM and datapath pipeline registers; done pulses on the OUTPUT->IDLE edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            output_sample <= '0;
            output_gain   <= '0;
            chan_q        <= '0;
            amt_q         <= '0;
            thr_q         <= '0;
            x_q           <= '0;
            lvl_q         <= '0;
            env_q         <= '0;
            prod_q        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ({1'b0, channel} < CH_LIMIT)) begin
                        chan_q <= channel;
                        amt_q  <= compression_amount;
                        thr_q  <= threshold;
                        x_q    <= input_sample;
                        state  <= DETECT;
                    end
                end
                DETECT: begin
                    lvl_q <= level;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    env_q <= env_next;
                    state <= MULTIPLY;
                end
                MULTIPLY: begin
                    prod_q <= prod;
                    state  <= OUTPUT;
                end
                OUTPUT: begin
                    // Integer octaves of attenuation are applied as an arithmetic shift.
                    output_sample <= WIDTH'((prod_q >>> 8) >>> env_q[7:3]);
                    output_gain   <= env_q;
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel envelope storage; only the channel being processed is written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 2**CW; c++) env[c] <= 8'd0;
        end else if (state == COMPUTE) begin
            env[chan_q] <= env_next;
        end
    end

endmodule

// File: tb/tb_dynamic_range_compressor.sv
// Bench for dynamic_range_compressor: directed scenarios with literal expectations,
// then randomized traffic (including starts while busy and mid-operation resets)
// checked every cycle against a behavioural model of the compressor.
module tb_dynamic_range_compressor;

    localparam int WIDTH    = 12;
    localparam int CHANNELS = 2;
    localparam int CW       = 1;
    localparam int EW       = 32 + 8 + WIDTH;
    localparam longint MAXV = (longint'(1) << (WIDTH - 1)) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CW-1:0]    channel = '0;
    logic [1:0]       amt = 2'd0;
    logic [7:0]       threshold = 8'd64;
    logic [WIDTH-1:0] input_sample = '0;
    logic [WIDTH-1:0] output_sample;
    logic [7:0]       output_gain;
    logic             busy;
    logic             done;
    logic [2:0]       state_dbg;

    logic             start3 = 1'b0;
    logic [1:0]       channel3 = 2'd0;
    logic [WIDTH-1:0] output_sample3;
    logic [7:0]       output_gain3;
    logic             busy3;
    logic             done3;
    logic [2:0]       state_dbg3;

    always #5 clock = ~clock;

    dynamic_range_compressor #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clock(clock), .reset(reset), .start(start), .channel(channel),
        .compression_amount(amt), .threshold(threshold), .input_sample(input_sample),
        .output_sample(output_sample), .output_gain(output_gain),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Three-channel instance: the only way to present an out-of-range channel index.
    dynamic_range_compressor #(.WIDTH(WIDTH), .CHANNELS(3)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .channel(channel3),
        .compression_amount(amt), .threshold(threshold), .input_sample(input_sample),
        .output_sample(output_sample3), .output_gain(output_gain3),
        .busy(busy3), .done(done3), .state_dbg(state_dbg3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lut [8] = '{256, 235, 215, 197, 181, 166, 152, 139};
    int env_m [CHANNELS];
    int cyc     = 0;
    int free_at = 0;
    bit chk_en  = 1'b0;
    logic [EW-1:0] exp_q[$];

    function automatic int level_of(input longint x);
        longint m;
        int p;
        m = (x < 0) ? -x : x;
        if (m > MAXV) m = MAXV;
        if (m == 0) return 0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return 8 * p + int'(((m * 8) >> p) % 8);
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint out_of(input longint x, input int env);
        return floor_div(floor_div(x * lut[env % 8], 256), longint'(1) << (env / 8));
    endfunction

    // Model of accepted transactions: one every 5 edges, valid channel only, reset clears all.
    always @(posedge clock) begin : model
        int ch, x, lvl, over, gr;
        longint y;
        cyc++;
        if (reset) begin
            chk_en  = 1'b1;
            free_at = cyc + 1;
            exp_q.delete();
            for (int c = 0; c < CHANNELS; c++) env_m[c] = 0;
        end else if (start === 1'b1 && int'(channel) < CHANNELS && cyc >= free_at) begin
            ch   = int'(channel);
            x    = int'($signed(input_sample));
            lvl  = level_of(x);
            over = (lvl > int'(threshold)) ? lvl - int'(threshold) : 0;
            gr   = over - (over >> amt);
`ifdef COMPRESSOR_RELEASE_EN
            if (gr >= env_m[ch]) env_m[ch] = gr;
            else env_m[ch] = env_m[ch] - 1;
`else
            env_m[ch] = gr;
`endif
            y = out_of(x, env_m[ch]);
            exp_q.push_back({32'(cyc + 4), 8'(env_m[ch]), WIDTH'(y)});
            free_at = cyc + 5;
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clock) begin : compare
        logic [EW-1:0] e;
        bit exp_busy;
        if (chk_en) begin
            exp_busy = (cyc < free_at - 1);
            check_val("busy", longint'(busy), longint'(exp_busy));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("done cycle", cyc, int'(e[EW-1:EW-32]));
                    check_val("output_sample", longint'($signed(output_sample)),
                              longint'($signed(e[WIDTH-1:0])));
                    check_val("output_gain", longint'(output_gain), longint'(e[WIDTH+7:WIDTH]));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][EW-1:EW-32]) < cyc) begin
                e = exp_q.pop_front();
                check_val("missing done", 0, 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse(input int ch, input int a, input int thr, input int x);
        @(negedge clock);
        channel      = CW'(ch);
        amt          = 2'(a);
        threshold    = 8'(thr);
        input_sample = WIDTH'(x);
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int ey, input int eg);
        int n;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        check_val({name, " latency"}, n, 5);
        check_val({name, " y"}, longint'($signed(output_sample)), ey);
        check_val({name, " gain"}, longint'(output_gain), eg);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n_done, y_seen, g_seen, busy_seen;

        // Pin the model's level detector with hand-computed values.
        check_val("model level 1024", level_of(1024), 80);
        check_val("model level -2048", level_of(-2048), 87);
        check_val("model level 3", level_of(3), 12);
        check_val("model out 1024 env14", out_of(1024, 14), 304);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_val("reset output_sample", longint'(output_sample), 0);
        check_val("reset output_gain", longint'(output_gain), 0);
        check_val("reset busy", longint'(busy), 0);
        check_val("reset done", longint'(done), 0);

        pulse(0, 1, 64, 0);
        wait_done("zero", 0, 0);
        pulse(0, 1, 64, 1024);
        wait_done("ch0 1024", 512, 8);
        pulse(1, 0, 64, 1024);
        wait_done("ch1 1024", 1024, 0);
`ifdef COMPRESSOR_RELEASE_EN
        pulse(0, 1, 64, 0);
        wait_done("release 0", 0, 7);
        pulse(0, 1, 64, 512);
        wait_done("release 512", 304, 6);
`else
        pulse(0, 1, 64, 0);
        wait_done("norelease 0", 0, 0);
        pulse(0, 1, 64, 512);
        wait_done("norelease 512", 362, 4);
`endif
        do_reset();
        pulse(0, 0, 64, -2048);
        wait_done("neg full", -2048, 0);
        do_reset();
        pulse(0, 3, 64, 1024);
        wait_done("ratio 8", 304, 14);

        // Starts during DETECT and MULTIPLY must be ignored without re-latching.
        do_reset();
        pulse(0, 1, 64, 1024);
        input_sample = '0;
        channel      = 1'b1;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        n_done = 0;
        y_seen = 0;
        g_seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (done === 1'b1) begin
                n_done++;
                y_seen = int'($signed(output_sample));
                g_seen = int'(output_gain);
            end
        end
        check_val("busy-start dones", n_done, 1);
        check_val("busy-start y", y_seen, 512);
        check_val("busy-start gain", g_seen, 8);

        // Reset while in COMPUTE aborts the sample.
        pulse(0, 1, 64, 1024);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(negedge clock);
            if (done === 1'b1) n_done++;
        end
        check_val("abort dones", n_done, 0);
        check_val("abort gain", longint'(output_gain), 0);
        check_val("abort busy", longint'(busy), 0);
        pulse(0, 1, 64, 0);
        wait_done("after abort", 0, 0);

        // Out-of-range channel on the three-channel instance.
        @(negedge clock);
        channel3 = 2'd3;
        start3   = 1'b1;
        busy_seen = 0;
        n_done    = 0;
        repeat (8) begin
            @(negedge clock);
            start3 = 1'b0;
            if (busy3 === 1'b1) busy_seen++;
            if (done3 === 1'b1) n_done++;
        end
        check_val("bad channel busy", busy_seen, 0);
        check_val("bad channel dones", n_done, 0);
        amt          = 2'd1;
        threshold    = 8'd64;
        input_sample = WIDTH'(1024);
        channel3     = 2'd2;
        start3       = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        check_val("ch2 busy", longint'(busy3), 1);
        n_done = 1;
        while (done3 !== 1'b1 && n_done < 12) begin
            @(negedge clock);
            n_done++;
        end
        check_val("ch2 latency", n_done, 5);
        check_val("ch2 y", longint'($signed(output_sample3)), 512);
        check_val("ch2 gain", longint'(output_gain3), 8);

        // Randomized traffic; the scoreboard checks every cycle.
        repeat (3000) begin
            @(negedge clock);
            start        = ($urandom_range(0, 2) == 0);
            channel      = CW'($urandom_range(0, CHANNELS - 1));
            amt          = 2'($urandom_range(0, 3));
            threshold    = ($urandom_range(0, 1) == 0) ? 8'd64 : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       input_sample = {1'b1, {(WIDTH - 1){1'b0}}};
                1:       input_sample = 12'(int'($urandom_range(0, 16)) - 8);
                default: input_sample = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            endcase
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check_val("drained queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
